noise_channel_gen: RTL

//  Parametrised APU noise voice (channel 4): clock-enabled LFSR noise generator with length counter,

---
 rtl/noise_channel_gen_if.sv | 31 +++
 rtl/noise_channel_gen.sv | 123 ++++++++++++
 2 files changed

// File: rtl/noise_channel_gen_if.sv
// Register/control bundle and status outputs for the noise voice.
// The master drives the register fields; the slave (the voice) drives wave/status.
interface noise_channel_gen_if #(
  parameter int unsigned LFSR_WIDTH = 15,
  parameter int unsigned OUT_WIDTH  = 24,
  parameter int unsigned LEN_WIDTH  = 6
);
  logic [LEN_WIDTH-1:0]  NR41_len;
  logic                  length_load;
  logic [7:0]            NR42;
  logic [7:0]            NR43;
  logic                  length_enable;
  logic                  trigger;
  logic                  length_tick;
  logic                  envelope_tick;
  logic [OUT_WIDTH-1:0]  wave;
  logic                  active;
  logic [LFSR_WIDTH-1:0] lfsr_dbg;

  modport master (
    output NR41_len, length_load, NR42, NR43, length_enable, trigger,
           length_tick, envelope_tick,
    input  wave, active, lfsr_dbg
  );

  modport slave (
    input  NR41_len, length_load, NR42, NR43, length_enable, trigger,
           length_tick, envelope_tick,
    output wave, active, lfsr_dbg
  );
endinterface

// File: rtl/noise_channel_gen.sv
// APU noise voice: prescaled frequency timer stepping an LFSR, length counter,
// volume envelope, trigger restart and DAC gating, all in one clock domain.
module noise_channel_gen #(
  parameter int unsigned LFSR_WIDTH  = 15,
  parameter int unsigned SHORT_WIDTH = 7,
  parameter int unsigned OUT_WIDTH   = 24,
  parameter int unsigned LEN_WIDTH   = 6,
  parameter int unsigned PRESCALE    = 4
) (
  input  logic system_clock,
  input  logic reset_n,
  noise_channel_gen_if.slave bus
);

  localparam int unsigned TIMER_W = 22;  // 112 << 15 still fits
  localparam int unsigned PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned CTR_W   = LEN_WIDTH + 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [CTR_W-1:0] FULL_LEN = CTR_W'(2 ** LEN_WIDTH);

  logic [LFSR_WIDTH-1:0] lfsr;
  logic [TIMER_W-1:0]    timer;
  logic [PRE_W-1:0]      prescaler;
  logic [CTR_W-1:0]      len_ctr;
  logic [2:0]            env_ctr;
  logic [3:0]            volume;
  logic                  active;
  logic [OUT_WIDTH-1:0]  wave;

  logic                  dac_on_c;
  logic                  frozen_c;
  logic [TIMER_W-1:0]    period_c;
  logic [LFSR_WIDTH-1:0] lfsr_next_c;
  logic                  len_dec_c;
  logic                  len_expire_c;
  logic                  env_step_c;
  logic [3:0]            amp_c;

  // Period, next LFSR state and event qualifiers
  always_comb begin
    logic fb;
    dac_on_c = |bus.NR42[7:3];
    frozen_c = bus.NR43[7:4] >= 4'd14;
    if (bus.NR43[2:0] == 3'd0) period_c = TIMER_W'(8);
    else                       period_c = TIMER_W'({bus.NR43[2:0], 4'b0000});
    period_c = period_c << bus.NR43[7:4];

    fb          = lfsr[0] ^ lfsr[1];
    lfsr_next_c = {fb, lfsr[LFSR_WIDTH-1:1]};
    if (bus.NR43[3]) lfsr_next_c[SHORT_WIDTH-1] = fb;

    // trigger and length_load both pre-empt a same-cycle length decrement
    len_dec_c    = bus.length_tick && bus.length_enable && (len_ctr != '0)
                   && !bus.trigger && !bus.length_load;
    len_expire_c = len_dec_c && (len_ctr == CTR_W'(1));
    env_step_c   = bus.envelope_tick && active && (bus.NR42[2:0] != 3'd0);
    amp_c        = (active && !lfsr[0]) ? volume : 4'h0;
  end

  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      lfsr      <= '1;
      timer     <= '0;
      prescaler <= '0;
      len_ctr   <= '0;
      env_ctr   <= '0;
      volume    <= '0;
      active    <= 1'b0;
      wave      <= '0;
    end else begin
      // Frequency timer and LFSR; the voice only runs while active
      if (bus.trigger) begin
        lfsr      <= '1;
        timer     <= period_c;
        prescaler <= '0;
      end else if (active && !frozen_c) begin
        if (prescaler == PRE_LAST) begin
          prescaler <= '0;
          if (timer < TIMER_W'(2)) begin
            timer <= period_c;
            lfsr  <= lfsr_next_c;
          end else begin
            timer <= timer - TIMER_W'(1);
          end
        end else begin
          prescaler <= prescaler + PRE_W'(1);
        end
      end

      if (bus.length_load)
        len_ctr <= FULL_LEN - CTR_W'(bus.NR41_len);
      else if (bus.trigger) begin
        if (len_ctr == '0) len_ctr <= FULL_LEN;
      end else if (len_dec_c)
        len_ctr <= len_ctr - CTR_W'(1);

      // DAC off overrides everything, including a trigger
      if (!dac_on_c)         active <= 1'b0;
      else if (bus.trigger)  active <= 1'b1;
      else if (len_expire_c) active <= 1'b0;

      if (bus.trigger) begin
        volume  <= bus.NR42[7:4];
        env_ctr <= bus.NR42[2:0];
      end else if (env_step_c) begin
        if (env_ctr < 3'd2) begin
          env_ctr <= bus.NR42[2:0];
          if (bus.NR42[3] && (volume != 4'hF))      volume <= volume + 4'd1;
          else if (!bus.NR42[3] && (volume != 4'h0)) volume <= volume - 4'd1;
        end else begin
          env_ctr <= env_ctr - 3'd1;
        end
      end

      wave <= {amp_c, {(OUT_WIDTH-4){1'b0}}};
    end
  end

  assign bus.wave     = wave;
  assign bus.active   = active;
  assign bus.lfsr_dbg = lfsr;

endmodule
